// File: rtl/vga_pkg.sv
// vga_pkg: definitions shared by the VGA output path.
//   BAYER          4x4 ordered-dither threshold table, indexed [y][x]
//   bayer_thr()    table lookup by 2-bit row/column phase
//   DEFAULT_IN_W   default pixel-generator bits per channel
//   HSYNC_POL_DEF  default active level of hsync (active low)
//   VSYNC_POL_DEF  default active level of vsync (active low)
package vga_pkg;

  localparam int DEFAULT_IN_W = 8;

  localparam bit HSYNC_POL_DEF = 1'b0;
  localparam bit VSYNC_POL_DEF = 1'b0;

  localparam logic [3:0] BAYER [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  function automatic logic [3:0] bayer_thr(input logic [1:0] y, input logic [1:0] x);
    return BAYER[y][x];
  endfunction

endpackage

// File: rtl/vga_chan_reduce.sv
// vga_chan_reduce: combinational depth reduction of one colour channel.
// The 4-bit threshold is scaled to the weight of the dropped bits, added
// to the input, and the top OUT_W bits kept; carry-out saturates to all-ones.
// Ports:
//   pix_in   IN_W   input channel value
//   thr      4      ordered-dither threshold (0 disables dithering)
//   pix_out  OUT_W  reduced channel value
module vga_chan_reduce #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 3
) (
  input  logic [IN_W-1:0]  pix_in,
  input  logic [3:0]       thr,
  output logic [OUT_W-1:0] pix_out
);

  localparam int D = IN_W - OUT_W;

  generate
    if (D == 0) begin : g_pass
      // Nothing dropped, so nothing to dither.
      logic unused_thr;
      assign unused_thr = ^thr;
      assign pix_out    = pix_in;
    end else begin : g_reduce
      logic [IN_W:0] off;
      logic [IN_W:0] sum;
      logic          unused_low;

      // Threshold spans 16 steps; align it to the 2^D range of dropped bits.
      if (D >= 4) begin : g_shl
        assign off = (IN_W+1)'(thr) << (D - 4);
      end else begin : g_shr
        assign off = (IN_W+1)'(thr >> (4 - D));
      end

      assign sum        = {1'b0, pix_in} + off;
      assign unused_low = ^sum[D-1:0];
      assign pix_out    = sum[IN_W] ? {OUT_W{1'b1}} : sum[IN_W-1:D];
    end
  endgenerate

endmodule

// File: rtl/vga_color_reducer.sv
// vga_color_reducer: registered colour-depth reducer between the pixel
// generator and the DAC pins, with optional 4x4 ordered dithering.
// Build option: define VGA_REDUCE_DITHER_EN to enable dithering and the
// x/y phase counters; otherwise channels are plainly truncated.
// Ports:
//   CLK, nRESET              clock, asynchronous active-low reset
//   pix_en                   pixel-rate enable; all registers hold when 0
//   hsync_in/vsync_in/de_in  timing from the pixel generator
//   r_in/g_in/b_in           IN_W-bit colour
//   hsync_out/vsync_out/de_out  timing delayed one pix_en
//   red/green/blue           reduced colour, delayed one pix_en, 0 when blanked
module vga_color_reducer
  import vga_pkg::*;
#(
  parameter int IN_W      = DEFAULT_IN_W,
  parameter int R_W       = 3,
  parameter int G_W       = 3,
  parameter int B_W       = 2,
  parameter bit HSYNC_POL = HSYNC_POL_DEF,
  parameter bit VSYNC_POL = VSYNC_POL_DEF
) (
  input  logic            CLK,
  input  logic            nRESET,
  input  logic            pix_en,
  input  logic            hsync_in,
  input  logic            vsync_in,
  input  logic            de_in,
  input  logic [IN_W-1:0] r_in,
  input  logic [IN_W-1:0] g_in,
  input  logic [IN_W-1:0] b_in,
  output logic            hsync_out,
  output logic            vsync_out,
  output logic            de_out,
  output logic [R_W-1:0]  red,
  output logic [G_W-1:0]  green,
  output logic [B_W-1:0]  blue
);

  logic [3:0]     thr;
  logic [R_W-1:0] r_red;
  logic [G_W-1:0] g_red;
  logic [B_W-1:0] b_red;

`ifdef VGA_REDUCE_DITHER_EN
  logic [1:0] x_q;
  logic [1:0] y_q;
  logic       vs_edge;
  logic       de_fall;

  // The delayed outputs double as the previous-pixel history for edge
  // detection: vsync_out resets inactive and de_out resets to 0.
  assign vs_edge = (vsync_in == VSYNC_POL) && (vsync_out != VSYNC_POL);
  assign de_fall = de_out && !de_in;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      x_q <= 2'd0;
      y_q <= 2'd0;
    end else if (pix_en) begin
      x_q <= de_in ? x_q + 2'd1 : 2'd0;
      // Frame start outranks the end-of-line step.
      if (vs_edge) begin
        y_q <= 2'd0;
      end else if (de_fall) begin
        y_q <= y_q + 2'd1;
      end
    end
  end

  assign thr = bayer_thr(y_q, x_q);
`else
  assign thr = 4'd0;
`endif

  vga_chan_reduce #(.IN_W(IN_W), .OUT_W(R_W)) u_red (
    .pix_in (r_in),
    .thr    (thr),
    .pix_out(r_red)
  );

  vga_chan_reduce #(.IN_W(IN_W), .OUT_W(G_W)) u_green (
    .pix_in (g_in),
    .thr    (thr),
    .pix_out(g_red)
  );

  vga_chan_reduce #(.IN_W(IN_W), .OUT_W(B_W)) u_blue (
    .pix_in (b_in),
    .thr    (thr),
    .pix_out(b_red)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      hsync_out <= ~HSYNC_POL;
      vsync_out <= ~VSYNC_POL;
      de_out    <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else if (pix_en) begin
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      de_out    <= de_in;
      // Blanking: the DAC must see black outside active video.
      red       <= de_in ? r_red : '0;
      green     <= de_in ? g_red : '0;
      blue      <= de_in ? b_red : '0;
    end
  end

endmodule

// File: tb/tb_vga_color_reducer.sv
// tb_vga_color_reducer: randomized and directed bench for vga_color_reducer
// (default parameters: 8-bit in, 3:3:2 out, active-low syncs). The
// reference model works from the dither rules in integer arithmetic.
module tb_vga_color_reducer;

  logic       clk;
  logic       rst_n;
  logic       pix_en;
  logic       hsync_in, vsync_in, de_in;
  logic [7:0] r_in, g_in, b_in;
  logic       hsync_out, vsync_out, de_out;
  logic [2:0] red, green;
  logic [1:0] blue;

  logic [10:0] out_vec;
  assign out_vec = {hsync_out, vsync_out, de_out, red, green, blue};

  localparam logic [10:0] RESET_OUT = {1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 2'd0};

`ifdef VGA_REDUCE_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  vga_color_reducer dut (
    .CLK      (clk),
    .nRESET   (rst_n),
    .pix_en   (pix_en),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .de_in    (de_in),
    .r_in     (r_in),
    .g_in     (g_in),
    .b_in     (b_in),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .de_out   (de_out),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] last_exp;

  int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  int m_x, m_y;
  bit m_prev_de, m_prev_vs_act;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_reduce(input int v, input int w, input int t);
    int d, off, s;
    d = 8 - w;
    if (d == 0) return v;
    off = (d >= 4) ? t * (1 << (d - 4)) : t / (1 << (4 - d));
    s = v + off;
    if (s > 255) return (1 << w) - 1;
    return s / (1 << d);
  endfunction

  function automatic logic [10:0] model_pixel(input logic hs, vs, de, input logic [7:0] r, g, b);
    int t;
    logic [10:0] e;
    t = DITHER ? bayer[m_y][m_x] : 0;
    e[10] = hs;
    e[9]  = vs;
    e[8]  = de;
    e[7:5] = de ? 3'(model_reduce(int'(r), 3, t)) : 3'd0;
    e[4:2] = de ? 3'(model_reduce(int'(g), 3, t)) : 3'd0;
    e[1:0] = de ? 2'(model_reduce(int'(b), 2, t)) : 2'd0;
    // phase bookkeeping: frame start (vsync going active, active low) beats line end
    if (!vs && !m_prev_vs_act) m_y = 0;
    else if (m_prev_de && !de) m_y = (m_y + 1) % 4;
    m_x = de ? (m_x + 1) % 4 : 0;
    m_prev_de = de;
    m_prev_vs_act = !vs;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic rst, input logic pe,
                      input logic hs, input logic vs, input logic de,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [10:0] e;
    @(negedge clk);
    rst_n = rst; pix_en = pe; hsync_in = hs; vsync_in = vs; de_in = de;
    r_in = r; g_in = g; b_in = b;
    if (!rst) begin
      m_x = 0; m_y = 0; m_prev_de = 1'b0; m_prev_vs_act = 1'b0;
      e = RESET_OUT;
    end else if (pe) begin
      e = model_pixel(hs, vs, de, r, g, b);
    end else begin
      e = last_exp;
    end
    last_exp = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, 32'(out_vec), 32'(exp_q.pop_front()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic de_r, vs_r;
    rst_n = 1'b0; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    last_exp = RESET_OUT;

    // reset held mid-line with pix_en pulsing and live colour
    for (int i = 0; i < 4; i++)
      step("reset_hold", 1'b0, 1'(i % 2), 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    check("reset_red", 32'(red), 32'd0);
    check("reset_sync", 32'({hsync_out, vsync_out, de_out}), 32'b110);

    // line y=0: x=0 (T=0) then x=1 (T=8)
    step("l0_p0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 8'h00);
    check("t3_x0_red", 32'(red), 32'd0);
    step("l0_p1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 8'h00);
    check("t3_x1_red", 32'(red), DITHER ? 32'd1 : 32'd0);
    step("l0_blank", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    check("blank_red", 32'(red), 32'd0);
    // lines y=1, y=2
    step("l1_p0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'hAA, 8'h33);
    step("l1_blank", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step("l2_p0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 8'h66, 8'hCC);
    step("l2_blank", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    // line y=3, x=0: T=15 saturates at the top
    step("l3_p0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hF0, 8'h00);
    check("t4_sat_red", 32'(red), 32'd7);
    check("t4_sat_green", 32'(green), 32'd7);
    step("l3_blank", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    // line y=0 then line y=1 whose end coincides with vsync going active
    step("l4_p0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h40, 8'h80);
    step("l4_blank", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step("l5_p0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h21, 8'h41, 8'h81);
    step("l5_p1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h42, 8'h82);
    step("vs_de_fall", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    check("vs_blank_red", 32'(red), 32'd0);
    step("vs_hold", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step("vs_end", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    // first pixel of the new frame: y cleared, so T=0
    step("f1_p0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hE5, 8'h10, 8'h7F);
    check("t2_red", 32'(red), 32'd7);
    check("t5_green_T0", 32'(green), 32'd0);
    check("t2_blue", 32'(blue), 32'd1);
    // pix_en stall mid-line with toggling inputs
    for (int i = 0; i < 10; i++)
      step("stall", 1'b1, 1'b0, 1'(i % 2), 1'(i % 2), 1'(~i % 2),
           8'($urandom), 8'($urandom), 8'($urandom));
    check("stall_red", 32'(red), 32'd7);
    step("f1_p1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'h10, 8'h00);
    check("resume_x1_red", 32'(red), DITHER ? 32'd1 : 32'd0);

    // randomized video-like traffic, with one reset mid-frame
    de_r = 1'b0;
    vs_r = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) de_r = ~de_r;
      if ($urandom_range(0, 29) == 0) vs_r = ~vs_r;
      step("rand", (i >= 400 && i < 403) ? 1'b0 : 1'b1,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), vs_r, de_r,
           8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
